// File: rtl/instr_pkg.sv
// Shared definitions for the instruction loader and the instruction memory.
// Latency: none (constants, types and a pure helper function only).
// Backpressure: none.
package instr_pkg;

  // Bytes per instruction word.
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned BYTE_BITS  = 8;

  // Loader FSM encoding.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  // Big-endian lane mapping: lane 0 is the lowest byte address and lands in
  // the most significant byte, exactly as the fetch side concatenates bytes.
  // Byte enable for lane n is LANE0_BE >> n.
  localparam logic [WORD_BYTES-1:0] LANE0_BE = 4'b1000;

  typedef logic [1:0] lane_t;

  // One word write towards the instruction memory.
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } mem_wr_t;

  // Bit offset of a lane inside the 32-bit word (lane 0 -> 24, lane 3 -> 0).
  function automatic logic [4:0] lane_shift(input lane_t lane);
    return 5'((WORD_BYTES - 1 - 32'(lane)) * BYTE_BITS);
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream into big-endian 32-bit words with per-lane byte enables.
// Latency: word/be are a combinational view including the byte being pushed.
// Backpressure: none; accepts a byte whenever push is high.
module byte_packer
  import instr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        push,
  input  logic        close,
  input  logic [7:0]  dat,
  output logic [31:0] word,
  output logic [3:0]  be,
  output logic        word_rdy
);

  lane_t       lane;
  logic [31:0] asm_word;
  logic [3:0]  asm_be;

  // Merge the presented byte into its lane; unfilled lanes stay zero.
  assign word = asm_word | ({24'd0, dat} << lane_shift(lane));
  assign be   = asm_be | (LANE0_BE >> lane);

  // A word is complete when its last lane fills or the caller closes it early.
  assign word_rdy = push && ((lane == lane_t'(WORD_BYTES - 1)) || close);

  // Lane counter and assembly register; cleared once a word is handed off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane     <= '0;
      asm_word <= '0;
      asm_be   <= '0;
    end else if (clr) begin
      lane     <= '0;
      asm_word <= '0;
      asm_be   <= '0;
    end else if (push) begin
      lane <= lane + 2'd1;
      if (word_rdy) begin
        asm_word <= '0;
        asm_be   <= '0;
      end else begin
        asm_word <= word;
        asm_be   <= be;
      end
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Loads a program byte stream into instruction memory as big-endian words, holding the core in reset.
// Latency: a word write is issued the cycle after the byte that completes (or ends) it is accepted.
// Backpressure: in_ready is high for the whole LOAD state; the memory write port is never stalled.
module instr_loader
  import instr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        core_rst_n,
  output logic        busy,
  output logic        done,
  output logic        err_overflow,
  output logic [31:0] byte_count
);

  localparam logic [31:0] MAX_CNT = 32'(MAX_BYTES);
  localparam logic [31:0] MAX_M1  = 32'(MAX_BYTES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [29:0] word_idx;
  mem_wr_t     wr_q;

  logic        accept;
  logic        load_start;
  logic        hit_max;
  logic [31:0] pk_word;
  logic [3:0]  pk_be;
  logic        wr_trig;

  // in_ready is a registered copy of "state is LOAD", so it qualifies acceptance directly.
  assign accept     = in_valid && in_ready;
  assign load_start = start && (state != LOAD);
  assign hit_max    = (byte_count == MAX_M1);

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clr      (load_start),
    .push     (accept),
    .close    (in_last || hit_max),
    .dat      (in_data),
    .word     (pk_word),
    .be       (pk_be),
    .word_rdy (wr_trig)
  );

  // Next-state: a load ends on the last byte, or overflows once MAX_BYTES are taken without one.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        if (accept) begin
          if (in_last)      state_nxt = DONE;
          else if (hit_max) state_nxt = ERR;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register and registered status outputs derived from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      in_ready     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_overflow <= 1'b0;
      core_rst_n   <= 1'b0;
    end else begin
      state        <= state_nxt;
      in_ready     <= (state_nxt == LOAD);
      busy         <= (state_nxt == LOAD);
      done         <= (state_nxt == DONE);
      err_overflow <= (state_nxt == ERR);
      core_rst_n   <= (state_nxt == DONE);
    end
  end

  // Accepted-byte counter (saturating) and word index, restarted by each new load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_count <= '0;
      word_idx   <= '0;
    end else if (load_start) begin
      byte_count <= '0;
      word_idx   <= '0;
    end else begin
      if (accept && (byte_count < MAX_CNT)) byte_count <= byte_count + 32'd1;
      if (wr_trig) word_idx <= word_idx + 30'd1;
    end
  end

  // Memory write port: one-cycle strobe; address/data hold between writes, enables drop to zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_we <= 1'b0;
      wr_q   <= '0;
    end else if (wr_trig) begin
      mem_we     <= 1'b1;
      wr_q.addr  <= BASE_ADDR + {word_idx, 2'b00};
      wr_q.wdata <= pk_word;
      wr_q.be    <= pk_be;
    end else begin
      mem_we  <= 1'b0;
      wr_q.be <= '0;
    end
  end

  assign mem_addr  = wr_q.addr;
  assign mem_wdata = wr_q.wdata;
  assign mem_be    = wr_q.be;

endmodule

// File: tb/tb_instr_loader.sv
// Randomized scoreboard bench for instr_loader: two instances (default size, and an 8-byte limit).
// Expected word writes come from a byte-list model and are popped by an independent monitor.
// Stream/handshake driving is in tasks; status checks are made away from the clock edge.
module tb_instr_loader;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } wr_t;
  typedef logic [7:0] bq_t[$];

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_1000;
  localparam int          MAX0  = 1024;
  localparam int          MAX1  = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_i [2];
  logic        valid_i [2];
  logic [7:0]  data_i  [2];
  logic        last_i  [2];
  logic        ready_o [2];
  logic        we_o    [2];
  logic [31:0] addr_o  [2];
  logic [31:0] wdata_o [2];
  logic [3:0]  be_o    [2];
  logic        crn_o   [2];
  logic        busy_o  [2];
  logic        done_o  [2];
  logic        err_o   [2];
  logic [31:0] cnt_o   [2];

  int  n_cmp = 0;
  int  n_bad = 0;
  wr_t q0[$];
  wr_t q1[$];

  instr_loader #(.BASE_ADDR(BASE0), .MAX_BYTES(MAX0)) dut0 (
    .clk(clk), .rst(rst), .start(start_i[0]), .in_valid(valid_i[0]), .in_data(data_i[0]),
    .in_last(last_i[0]), .in_ready(ready_o[0]), .mem_we(we_o[0]), .mem_addr(addr_o[0]),
    .mem_wdata(wdata_o[0]), .mem_be(be_o[0]), .core_rst_n(crn_o[0]), .busy(busy_o[0]),
    .done(done_o[0]), .err_overflow(err_o[0]), .byte_count(cnt_o[0])
  );

  instr_loader #(.BASE_ADDR(BASE1), .MAX_BYTES(MAX1)) dut1 (
    .clk(clk), .rst(rst), .start(start_i[1]), .in_valid(valid_i[1]), .in_data(data_i[1]),
    .in_last(last_i[1]), .in_ready(ready_o[1]), .mem_we(we_o[1]), .mem_addr(addr_o[1]),
    .mem_wdata(wdata_o[1]), .mem_be(be_o[1]), .core_rst_n(crn_o[1]), .busy(busy_o[1]),
    .done(done_o[1]), .err_overflow(err_o[1]), .byte_count(cnt_o[1])
  );

  function automatic logic [31:0] base_of(input int sel);
    return (sel == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int max_of(input int sel);
    return (sel == 0) ? MAX0 : MAX1;
  endfunction

  task automatic chk(input string nm, input int sel, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (dut%0d): got %h, expected %h at %0t", nm, sel, act, exp, $time);
    end
  endtask

  // Reference: accepted bytes are cut into 4-byte groups in address order; the first byte of a
  // group is the top byte of the word, missing trailing bytes read as zero with enable low.
  task automatic model(input int sel, input bq_t b, input bit has_last,
                       output int n_acc, output bit exp_done);
    int n;
    int mx;
    n        = b.size();
    mx       = max_of(sel);
    exp_done = has_last && (n <= mx);
    n_acc    = exp_done ? n : ((n < mx) ? n : mx);
    for (int w = 0; w * 4 < n_acc; w++) begin
      wr_t e;
      e.addr = base_of(sel) + 32'(4 * w);
      e.data = '0;
      e.be   = '0;
      for (int j = 0; j < 4; j++) begin
        if (w * 4 + j < n_acc) begin
          e.data     = e.data | (32'(b[w * 4 + j]) << (8 * (3 - j)));
          e.be[3 - j] = 1'b1;
        end
      end
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        if (we_o[k]) begin
          wr_t e;
          int  qs;
          qs = (k == 0) ? q0.size() : q1.size();
          if (qs == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_write (dut%0d): got addr %h data %h be %b, expected no write",
                     k, addr_o[k], wdata_o[k], be_o[k]);
          end else begin
            if (k == 0) e = q0.pop_front();
            else        e = q1.pop_front();
            chk("wr_addr", k, addr_o[k], e.addr);
            chk("wr_data", k, wdata_o[k], e.data);
            chk("wr_be", k, 32'(be_o[k]), 32'(e.be));
          end
        end else begin
          chk("be_idle", k, 32'(be_o[k]), 32'd0);
        end
        if (busy_o[k]) chk("ready_in_load", k, 32'(ready_o[k]), 32'd1);
      end
    end
  end

  task automatic check_zero(input int sel);
    chk("rst_in_ready", sel, 32'(ready_o[sel]), 32'd0);
    chk("rst_mem_we", sel, 32'(we_o[sel]), 32'd0);
    chk("rst_mem_addr", sel, addr_o[sel], 32'd0);
    chk("rst_mem_wdata", sel, wdata_o[sel], 32'd0);
    chk("rst_mem_be", sel, 32'(be_o[sel]), 32'd0);
    chk("rst_core_rst_n", sel, 32'(crn_o[sel]), 32'd0);
    chk("rst_busy", sel, 32'(busy_o[sel]), 32'd0);
    chk("rst_done", sel, 32'(done_o[sel]), 32'd0);
    chk("rst_err", sel, 32'(err_o[sel]), 32'd0);
    chk("rst_byte_count", sel, cnt_o[sel], 32'd0);
  endtask

  // Pulse start across one rising edge; the core must be held in reset from that edge on.
  task automatic start_load(input int sel);
    start_i[sel] = 1'b1;
    @(negedge clk);
    start_i[sel] = 1'b0;
    #1;
    chk("start_core_rst_n", sel, 32'(crn_o[sel]), 32'd0);
    chk("start_busy", sel, 32'(busy_o[sel]), 32'd1);
    chk("start_in_ready", sel, 32'(ready_o[sel]), 32'd1);
    chk("start_byte_count", sel, cnt_o[sel], 32'd0);
  endtask

  // Present one byte until accepted or the cycle budget runs out; returns after the edge.
  task automatic put_byte(input int sel, input logic [7:0] d, input logic l,
                          input int budget, output bit ok);
    ok = 1'b0;
    valid_i[sel] = 1'b1;
    data_i[sel]  = d;
    last_i[sel]  = l;
    for (int t = 0; t < budget && !ok; t++) begin
      ok = ready_o[sel];
      @(negedge clk);
    end
    valid_i[sel] = 1'b0;
    data_i[sel]  = 8'($urandom);
    last_i[sel]  = 1'($urandom);
  endtask

  task automatic check_end(input int sel, input bit exp_done, input int exp_cnt);
    repeat (3) @(negedge clk);
    #1;
    chk("writes_drained", sel, (sel == 0) ? 32'(q0.size()) : 32'(q1.size()), 32'd0);
    chk("end_done", sel, 32'(done_o[sel]), 32'(exp_done));
    chk("end_err_overflow", sel, 32'(err_o[sel]), 32'(!exp_done));
    chk("end_core_rst_n", sel, 32'(crn_o[sel]), 32'(exp_done));
    chk("end_in_ready", sel, 32'(ready_o[sel]), 32'd0);
    chk("end_busy", sel, 32'(busy_o[sel]), 32'd0);
    chk("end_byte_count", sel, cnt_o[sel], 32'(exp_cnt));
  endtask

  task automatic run_stream(input int sel, input bq_t b, input bit has_last, input int max_gap);
    int n_acc;
    bit exp_done;
    bit ok;
    model(sel, b, has_last, n_acc, exp_done);
    start_load(sel);
    for (int i = 0; i < b.size(); i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge clk);
      put_byte(sel, b[i], has_last && (i == b.size() - 1), (i < n_acc) ? 20 : 4, ok);
      chk("byte_accept", sel, 32'(ok), 32'(i < n_acc));
      if (i == 0 && ok) chk("count_first", sel, cnt_o[sel], 32'd1);
      if (!ok) break;
    end
    check_end(sel, exp_done, n_acc);
  endtask

  initial begin
    #500000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t b;
    bq_t prog;
    bit  ok;
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_i[k] = 1'b0;
      valid_i[k] = 1'b0;
      data_i[k]  = 8'h00;
      last_i[k]  = 1'b0;
    end
    #3;
    check_zero(0);
    check_zero(1);
    #4;
    check_zero(0);
    @(negedge clk);
    rst = 1'b1;

    // Single word.
    b = {8'h01, 8'h49, 8'h83, 8'h33};
    run_stream(0, b, 1'b1, 0);

    // Three words, last one partial; restarts from DONE.
    prog = {8'h01, 8'h49, 8'h83, 8'h33, 8'h00, 8'h6e, 8'h83, 8'h93, 8'h40, 8'hc5, 8'h85};
    run_stream(0, prog, 1'b1, 0);

    // First eight bytes with random valid gaps.
    b = prog[0:7];
    run_stream(0, b, 1'b1, 5);

    // Overflow on the 8-byte instance: ninth byte must be refused.
    b = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99};
    run_stream(1, b, 1'b0, 0);

    // Fresh load out of ERR.
    b = {8'hca, 8'hfe, 8'hf0};
    run_stream(1, b, 1'b1, 2);

    // Random programs on the large instance.
    for (int r = 0; r < 8; r++) begin
      int n;
      n = $urandom_range(1, 40);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      run_stream(0, b, 1'b1, $urandom_range(0, 3));
    end

    // Random programs on the small instance: either terminate or overflow.
    for (int r = 0; r < 8; r++) begin
      int n;
      bit lst;
      lst = 1'($urandom);
      n   = lst ? $urandom_range(1, MAX1) : $urandom_range(MAX1, MAX1 + 2);
      b = {};
      for (int i = 0; i < n; i++) b.push_back(8'($urandom));
      run_stream(1, b, lst, $urandom_range(0, 3));
    end

    // Reset mid-word: nothing written, everything cleared immediately.
    start_load(0);
    put_byte(0, 8'haa, 1'b0, 20, ok);
    chk("rst_test_byte0", 0, 32'(ok), 32'd1);
    put_byte(0, 8'hbb, 1'b0, 20, ok);
    chk("rst_test_byte1", 0, 32'(ok), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_zero(0);
    check_zero(1);
    @(negedge clk);
    rst = 1'b1;
    b = {8'hde, 8'had, 8'hbe, 8'hef};
    run_stream(0, b, 1'b1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
